frame_feed_fifo: RTL and testbench
==================================

// Module: frame_feed_fifo
// PURPOSE
//  Upstream stage of the console shift registers: buffers controller frames written by the
//  host/MCU side and presents the head frame on next_frame for the shift register's parallel
//  load. Advances one frame per console latch pulse, detected on the latch falling edge.
//  When empty, it presents the idle frame (all buttons released) and records an underflow.
// PARAMETERS
//  WIDTH      16          frame width in bits (8/16/32/64, matching the shift register fed)
//  DEPTH      64          FIFO entries; power of two, >= 2
//  IDLE_FRAME {WIDTH{1'b1}} value shown when empty or disabled
// PORTS
//  clk            in   1            system clock, all state on rising edge
//  rst            in   1            asynchronous reset, active-high
//  enable         in   1            1 = latch pulses consume frames; 0 = hold FIFO, show IDLE_FRAME
//  wr_data        in   WIDTH        frame from host
//  wr_valid       in   1            wr_data valid this cycle
//  wr_ready       out  1            FIFO can accept; write occurs when wr_valid & wr_ready
//  latch          in   1            raw console latch, asynchronous to clk
//  next_frame     out  WIDTH        registered head frame, to shift register next_frame
//  level          out  log2(DEPTH)+1 entries currently stored, 0..DEPTH
//  frame_count    out  32           latch pulses consumed while enabled, wraps at 2^32
//  underflow      out  1            sticky: a latch pulse found the FIFO empty
//  clr_underflow  in   1            synchronous clear of underflow; set wins if same cycle
// BEHAVIOUR
//  Reset (async assert, sync-released domain): rd/wr pointers=0, level=0, wr_ready=1,
//   next_frame=IDLE_FRAME, frame_count=0, underflow=0, latch synchronizer=0.
//  Latch sync: 2 flops (l1,l2) plus l3 for edge detect; pop strobe = l3 & ~l2 (falling edge).
//   Strobe is 1 cycle wide, asserting 3 clk after latch falls (+/-1 for metastability).
//   Pulses shorter than 2 clk may be missed; the bench keeps latch high >= 3 clk.
//  Pop strobe with enable=1:
//   - level>0: rd_ptr++, level--, frame_count++.
//   - level=0: no pointer change, frame_count++, underflow<=1.
//  Pop strobe with enable=0: ignored entirely (no count, no underflow).
//  Write: when wr_valid & wr_ready: mem[wr_ptr]<=wr_data, wr_ptr++. Pointers wrap modulo DEPTH.
//  wr_ready = (level != DEPTH), combinational from level. A write while full is dropped
//   (ready=0), with no bypass, even if a pop occurs in the same cycle.
//  Simultaneous write+pop: level unchanged when level>0. When level=0, the pop counts as
//   underflow and the write is stored, giving level=1.
//  next_frame is registered and updated every cycle from post-update state:
//   next_frame <= (enable && level_next>0) ? mem[rd_ptr_next] : IDLE_FRAME.
//   This gives 1 clk latency from the accepting write/pop to the visible change. The value is
//   stable between pops, so the shift register's async load sees a settled frame while latch
//   is high.
//  Frame order is strictly FIFO; no frame is presented twice or skipped except as specified.
//  Reset mid-operation clears all stored frames immediately. next_frame goes to IDLE_FRAME
//   asynchronously with rst.
// TESTING
//  1. Reset, idle: rst pulse -> next_frame=FFFF, level=0, wr_ready=1, underflow=0.
//  2. Write 16'h1234, 16'hABCD, then one latch pulse (high 4 clk):
//     -> next_frame=1234 1 clk after first write; =ABCD 4 clk after latch falls;
//        level=1, frame_count=1.
//  3. Empty latch: latch pulse with level=0 -> next_frame stays FFFF, underflow=1,
//     frame_count+1; clr_underflow -> 0.
//  4. Fill DEPTH=64 frames 0..63 -> level=64, wr_ready=0, 65th write dropped;
//     64 latches output 0..63 in order, then FFFF.
//  5. Same cycle write+pop at level=3 -> level stays 3; at level=0 -> level=1, underflow=1.
//  6. enable=0 with level=2, latch pulses -> next_frame=FFFF, level=2, frame_count unchanged;
//     enable=1 -> head reappears next clk. Assert rst while latch is high -> all outputs at
//     reset values, no pop on release.

Source files
------------

// File: rtl/frame_feed_fifo.sv
// Frame FIFO feeding the console shift register: host writes frames, each console latch
// falling edge advances the head; idle frame is shown when empty or disabled.
module frame_feed_fifo #(
  parameter int                 WIDTH      = 16,
  parameter int                 DEPTH      = 64,
  parameter logic [WIDTH-1:0]   IDLE_FRAME = {WIDTH{1'b1}}
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic                      latch,
  output logic [WIDTH-1:0]          next_frame,
  output logic [$clog2(DEPTH):0]    level,
  output logic [31:0]               frame_count,
  output logic                      underflow,
  input  logic                      clr_underflow
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic [31:0]      frame_count_q, frame_count_d;
  logic             underflow_q, underflow_d;
  logic [WIDTH-1:0] next_frame_q, next_frame_d;
  logic             l1_q, l2_q, l3_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             pop_stb, pop_en, do_pop, pop_empty, do_write;
  logic [AW:0]      kept;

  assign wr_ready    = (level_q != (AW+1)'(DEPTH));
  assign next_frame  = next_frame_q;
  assign level       = level_q;
  assign frame_count = frame_count_q;
  assign underflow   = underflow_q;

  always_comb begin
    pop_stb       = l3_q & ~l2_q;
    pop_en        = pop_stb & enable;
    do_write      = wr_valid & wr_ready;
    do_pop        = pop_en & (level_q != '0);
    pop_empty     = pop_en & (level_q == '0);
    rd_ptr_d      = rd_ptr_q + AW'(do_pop);
    wr_ptr_d      = wr_ptr_q + AW'(do_write);
    kept          = level_q - (AW+1)'(do_pop);
    level_d       = kept + (AW+1)'(do_write);
    frame_count_d = frame_count_q + 32'(pop_en);
    underflow_d   = pop_empty | (underflow_q & ~clr_underflow);
    // When no old entry survives this cycle, the head is the frame being written now,
    // which is not yet visible in mem_q.
    if (!enable || level_d == '0)
      next_frame_d = IDLE_FRAME;
    else if (do_write && kept == '0)
      next_frame_d = wr_data;
    else
      next_frame_d = mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      level_q       <= '0;
      frame_count_q <= '0;
      underflow_q   <= 1'b0;
      next_frame_q  <= IDLE_FRAME;
      l1_q          <= 1'b0;
      l2_q          <= 1'b0;
      l3_q          <= 1'b0;
    end else begin
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      level_q       <= level_d;
      frame_count_q <= frame_count_d;
      underflow_q   <= underflow_d;
      next_frame_q  <= next_frame_d;
      l1_q          <= latch;
      l2_q          <= l1_q;
      l3_q          <= l2_q;
    end
  end

  // Storage needs no reset; level and pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_write) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: tb/tb_frame_feed_fifo.sv
// Directed bench for frame_feed_fifo with hand-computed expectations.
module tb_frame_feed_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] wr_data = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic        latch = 1'b0;
  logic [15:0] next_frame;
  logic [6:0]  level;
  logic [31:0] frame_count;
  logic        underflow;
  logic        clr_underflow = 1'b0;

  int checks = 0;
  int errors = 0;

  frame_feed_fifo #(.WIDTH(16), .DEPTH(64)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .latch(latch), .next_frame(next_frame), .level(level),
    .frame_count(frame_count), .underflow(underflow),
    .clr_underflow(clr_underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [15:0] d);
    wr_data  = d;
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic pulse();
    latch = 1'b1;
    repeat (4) tick();
    latch = 1'b0;
    repeat (5) tick();
  endtask

  // Pop strobe is consumed on the third edge after latch falls; write lands on that edge.
  task automatic pulse_with_write(input logic [15:0] d);
    latch = 1'b1;
    repeat (4) tick();
    latch = 1'b0;
    repeat (2) tick();
    write(d);
    repeat (3) tick();
  endtask

  initial begin
    // 1. reset / idle
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_next_frame", 64'(next_frame), 64'hFFFF);
    check("rst_level", 64'(level), 0);
    check("rst_wr_ready", 64'(wr_ready), 1);
    check("rst_underflow", 64'(underflow), 0);
    check("rst_frame_count", 64'(frame_count), 0);
    enable = 1'b1;
    tick();

    // 2. two writes, one pop
    write(16'h1234);
    check("w1_next_frame", 64'(next_frame), 64'h1234);
    check("w1_level", 64'(level), 1);
    write(16'hABCD);
    check("w2_next_frame", 64'(next_frame), 64'h1234);
    check("w2_level", 64'(level), 2);
    pulse();
    check("p1_next_frame", 64'(next_frame), 64'hABCD);
    check("p1_level", 64'(level), 1);
    check("p1_frame_count", 64'(frame_count), 1);

    // 3. drain, then pop on empty
    pulse();
    check("p2_next_frame", 64'(next_frame), 64'hFFFF);
    check("p2_level", 64'(level), 0);
    check("p2_underflow", 64'(underflow), 0);
    pulse();
    check("uf_next_frame", 64'(next_frame), 64'hFFFF);
    check("uf_underflow", 64'(underflow), 1);
    check("uf_frame_count", 64'(frame_count), 3);
    clr_underflow = 1'b1;
    tick();
    clr_underflow = 1'b0;
    check("uf_cleared", 64'(underflow), 0);

    // 4. fill to DEPTH, overflow write dropped, drain in order
    for (int i = 0; i < 64; i++) write(16'(i));
    check("full_level", 64'(level), 64);
    check("full_wr_ready", 64'(wr_ready), 0);
    check("full_head", 64'(next_frame), 0);
    write(16'hDEAD);
    check("ovf_level", 64'(level), 64);
    for (int i = 0; i < 64; i++) begin
      check("drain_order", 64'(next_frame), 64'(i));
      pulse();
    end
    check("drain_next_frame", 64'(next_frame), 64'hFFFF);
    check("drain_level", 64'(level), 0);
    check("drain_frame_count", 64'(frame_count), 67);
    check("drain_underflow", 64'(underflow), 0);

    // 5. simultaneous write + pop
    write(16'h0100);
    write(16'h0101);
    write(16'h0102);
    check("l3_level", 64'(level), 3);
    pulse_with_write(16'h0103);
    check("wp3_level", 64'(level), 3);
    check("wp3_next_frame", 64'(next_frame), 64'h0101);
    check("wp3_frame_count", 64'(frame_count), 68);
    repeat (3) pulse();
    check("wp3_drained", 64'(level), 0);
    check("wp3_last_count", 64'(frame_count), 71);
    pulse_with_write(16'h0200);
    check("wp0_level", 64'(level), 1);
    check("wp0_underflow", 64'(underflow), 1);
    check("wp0_next_frame", 64'(next_frame), 64'h0200);
    check("wp0_frame_count", 64'(frame_count), 72);
    clr_underflow = 1'b1;
    tick();
    clr_underflow = 1'b0;

    // 6. disable holds FIFO and shows idle frame
    write(16'h0201);
    check("dis_pre_level", 64'(level), 2);
    enable = 1'b0;
    tick();
    check("dis_next_frame", 64'(next_frame), 64'hFFFF);
    pulse();
    pulse();
    check("dis_level", 64'(level), 2);
    check("dis_frame_count", 64'(frame_count), 72);
    check("dis_underflow", 64'(underflow), 0);
    check("dis_idle_hold", 64'(next_frame), 64'hFFFF);
    enable = 1'b1;
    tick();
    check("en_head", 64'(next_frame), 64'h0200);

    // reset while latch high
    latch = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    check("amid_next_frame", 64'(next_frame), 64'hFFFF);
    check("amid_level", 64'(level), 0);
    check("amid_frame_count", 64'(frame_count), 0);
    tick();
    rst = 1'b0;
    repeat (6) tick();
    check("rel_frame_count", 64'(frame_count), 0);
    check("rel_underflow", 64'(underflow), 0);
    check("rel_wr_ready", 64'(wr_ready), 1);
    check("rel_next_frame", 64'(next_frame), 64'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
